// File: rtl/block_loader.sv
// block_loader: collects WORDS plaintext words of WORD_W bits into one
// 128-bit block and presents it to the cell-shuffle stage with a
// valid/ready handshake. The first accepted word lands in the most
// significant word of the block.
//
// Optional feature: define BLOCK_LOADER_WHITEN_EN to XOR the assembled
// block with wkey, which is sampled on the edge that accepts the final
// word. Without the macro, wkey is ignored and the timing is unchanged.
module block_loader #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_word,
    input  logic [127:0]        wkey,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_block,
    output logic [2:0]          words_cnt
);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    localparam logic [2:0] LAST_IDX = 3'(WORDS - 1);

    logic [0:0]   state_reg;
    logic [0:0]   state_next;
    logic [2:0]   cnt_reg;
    logic [2:0]   cnt_next;
    logic [127:0] block_reg;
    logic [127:0] assembled;
    logic [127:0] loaded;
    logic         accept;
    logic         last_word;

    // A word is taken only while filling and not being flushed.
    assign accept    = (state_reg == FILL) && in_valid && !flush;
    assign last_word = accept && (cnt_reg == LAST_IDX);

    // Word k occupies the k-th word slot counted from the MSB end. The
    // final slot is fed straight from in_word so the complete block can be
    // registered on the same edge that accepts the last word.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            if (gi < WORDS - 1) begin : g_store
                logic [WORD_W-1:0] word_reg;

                // Capture the word whose position matches the current fill count.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        word_reg <= '0;
                    end else if (accept && (cnt_reg == 3'(gi))) begin
                        word_reg <= in_word;
                    end
                end

                assign assembled[WORD_W*(WORDS-gi)-1 -: WORD_W] = word_reg;
            end else begin : g_direct
                assign assembled[WORD_W*(WORDS-gi)-1 -: WORD_W] = in_word;
            end
        end
    endgenerate

`ifdef BLOCK_LOADER_WHITEN_EN
    assign loaded = assembled ^ wkey;
`else
    logic unused_wkey;
    assign unused_wkey = ^wkey;
    assign loaded      = assembled;
`endif

    // Next-state logic: flush wins over everything except reset; in HOLD
    // the only way back to FILL is a completed handshake or a flush.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (flush) begin
            state_next = FILL;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (accept) begin
                        cnt_next = cnt_reg + 3'd1;
                        if (last_word) begin
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_next = FILL;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = FILL;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // State, fill count and the presented block; the block is only
    // rewritten when the final word arrives, so it stays stable in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FILL;
            cnt_reg   <= '0;
            block_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (last_word) begin
                block_reg <= loaded;
            end
        end
    end

    assign in_ready  = (state_reg == FILL);
    assign out_valid = (state_reg == HOLD);
    assign out_block = block_reg;
    assign words_cnt = cnt_reg;

endmodule

// File: doc/block_loader.md
BLOCK_LOADER -- requirements
Module: block_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 32, input bus word width in bits.
REQ-002 SHALL have parameter WORDS, default 4, words per block; WORD_W*WORDS SHALL equal 128, and other values are unsupported.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, synchronous abort of the partial or held block.
REQ-006 SHALL have port in_valid, input, 1, the upstream word is valid.
REQ-007 SHALL have port in_ready, output, 1, the block accepts a word this cycle.
REQ-008 SHALL have port in_word, input, WORD_W, plaintext word.
REQ-009 SHALL have port wkey, input, 128, whitening key.
REQ-010 SHALL have port out_valid, output, 1, the assembled block is presented.
REQ-011 SHALL have port out_ready, input, 1, the downstream cell-shuffle stage consumes the block.
REQ-012 SHALL have port out_block, output, 128, block for the shuffle stage input (nibble i = bits [4i+3:4i]).
REQ-013 SHALL have port words_cnt, output, 3, number of words accepted in the current fill.

Function
REQ-014 SHALL implement a two-state FSM: FILL (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 SHALL accept a word in FILL when in_valid=1 and flush=0, incrementing words_cnt by 1.
REQ-016 SHALL place the k-th accepted word (k=0..3) into bits [127-32k : 96-32k], so the first word lands in the most significant word.
REQ-017 SHALL, on acceptance of the word making words_cnt reach WORDS, register the full block and transition to HOLD on that edge; out_valid rises the following cycle (1-cycle latency from last word to out_valid).
REQ-018 SHALL sample wkey only on the edge that accepts the final word; wkey changes at any other time SHALL NOT affect out_block.
REQ-019 SHALL hold out_block and out_valid stable in HOLD until out_valid=1 and out_ready=1 on the same edge.
REQ-020 SHALL, on that handshake edge, return to FILL with words_cnt=0; the next word is accepted no earlier than the following cycle (no overlap; peak rate one block per WORDS+1 cycles).
REQ-021 SHALL ignore in_valid in HOLD, since in_ready=0 there.
REQ-022 SHALL, when flush=1 in any state, go to FILL with words_cnt=0 and out_valid=0 on that edge, discarding any word presented that cycle and any held block.
REQ-023 SHALL, when flush=1 and out_ready=1 coincide in HOLD, give flush priority: the block is not counted as delivered, and the bench SHALL treat it as dropped.
REQ-024 SHALL keep words_cnt in range 0..WORDS; words_cnt=WORDS only in HOLD.
REQ-025 SHALL be fully synchronous with no combinational path from in_valid/in_word to out_*; out_ready SHALL affect only state.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set state to FILL, words_cnt=0, in_ready=1 (after reset), out_valid=0, and out_block=128'h0.
REQ-027 SHALL give rst priority over flush and over every handshake; a partial block during reset is lost.

Configuration
REQ-028 SHALL, when macro BLOCK_LOADER_WHITEN_EN is defined, output out_block = assembled words XOR sampled wkey.
REQ-029 SHALL, when BLOCK_LOADER_WHITEN_EN is undefined, output out_block = assembled words unmodified; wkey SHALL then be unused and all timing SHALL be identical.

Verification
REQ-030 SHALL cover basic load, macro off: words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on consecutive cycles, out_ready=1 -> out_valid one cycle after word 4, out_block=128'h00112233_44556677_8899AABB_CCDDEEFF, held one cycle, then in_ready=1.
REQ-031 SHALL cover whitening, macro on: same words with wkey=128'hFFFF...FF -> out_block=128'hFFEEDDCC_BBAA9988_77665544_33221100; changing wkey during HOLD -> out_block unchanged.
REQ-032 SHALL cover backpressure: out_ready=0 for 5 cycles after out_valid -> out_block stable, in_ready=0, and extra in_valid words ignored; out_ready=1 -> delivered once, words_cnt=0.
REQ-033 SHALL cover mid-fill flush: 2 words accepted, then flush=1 with in_valid=1 -> words_cnt=0 and that word dropped; the next 4 words form a block containing only the new words.
REQ-034 SHALL cover flush vs. handshake: in HOLD, flush=1 and out_ready=1 together -> out_valid=0 next cycle and the block counted as dropped.
REQ-035 SHALL cover reset mid-operation: rst=1 after 3 words or in HOLD -> next cycle out_valid=0, words_cnt=0, out_block=0, in_ready=1.
